// File: rtl/sfp_link_mgr_pkg.sv
// Shared types and constants for the SFP+ link supervisor.
package sfp_link_mgr_pkg;

  typedef enum logic [2:0] {
    DISABLED  = 3'd0,
    WAIT_PLL  = 3'd1,
    RESET     = 3'd2,
    WAIT_LINK = 3'd3,
    UP        = 3'd4
  } link_state_t;

  localparam logic [7:0]  XGMII_SEQ = 8'h9C;
  localparam logic [23:0] LF_CODE   = 24'h010000;
  localparam logic [23:0] RF_CODE   = 24'h020000;

  // True when either XGMII column (lane 0 or lane 4) carries the given sequence ordered set.
  function automatic logic seq_match(input logic [63:0] rxd, input logic [7:0] rxc,
                                     input logic [23:0] code);
    logic lane0;
    logic lane4;
    lane0 = rxc[0] && (rxd[7:0] == XGMII_SEQ) && (rxd[31:8] == code);
    lane4 = rxc[4] && (rxd[39:32] == XGMII_SEQ) && (rxd[63:40] == code);
    return lane0 || lane4;
  endfunction

endpackage

// File: rtl/sfp_link_mgr_fsm.sv
// One port's link supervisor: fault decode, bring-up/qualify FSM and link-down counter.
module sfp_link_fsm
  import sfp_link_mgr_pkg::*;
#(
  parameter int RESET_CYCLES   = 256,
  parameter int LINK_OK_CYCLES = 1024,
  parameter int FAULT_CYCLES   = 4,
  parameter int LINK_TIMEOUT   = 1048576,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             qplllock,
  input  logic             reset_counter_done,
  input  logic             sfp_absent,
  input  logic             sfp_tx_fault,
  input  logic [63:0]      xgmii_rxd,
  input  logic [7:0]       xgmii_rxc,
  output logic             sfp_tx_disable,
  output logic             port_rst,
  output logic             link_up,
  output logic             remote_fault,
  output logic [CNT_W-1:0] link_down_count
);

  // One phase counter serves RESET (hold length), WAIT_LINK (clean run) and UP (fault run).
  localparam int PH_MAX0 = (RESET_CYCLES > LINK_OK_CYCLES) ? RESET_CYCLES : LINK_OK_CYCLES;
  localparam int PH_MAX  = (PH_MAX0 > FAULT_CYCLES) ? PH_MAX0 : FAULT_CYCLES;
  localparam int CW      = $clog2(PH_MAX) + 1;
  localparam int TW      = $clog2(LINK_TIMEOUT) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] OK_LAST  = CW'(LINK_OK_CYCLES - 1);
  localparam logic [CW-1:0] FLT_LAST = CW'(FAULT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LINK_TIMEOUT - 1);

  link_state_t      state_reg, state_next;
  logic [CW-1:0]    ph_cnt_reg, ph_cnt_next;
  logic [TW-1:0]    to_cnt_reg, to_cnt_next;
  logic             fault_reg, rf_reg;
  logic             tx_dis_reg, tx_dis_next;
  logic             rst_reg, rst_next;
  logic             up_reg, up_next;
  logic [CNT_W-1:0] dn_cnt_reg, dn_cnt_next;

  // State, counters, registered fault decode and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= DISABLED;
      ph_cnt_reg <= '0;
      to_cnt_reg <= '0;
      fault_reg  <= 1'b0;
      rf_reg     <= 1'b0;
      tx_dis_reg <= 1'b1;
      rst_reg    <= 1'b1;
      up_reg     <= 1'b0;
      dn_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ph_cnt_reg <= ph_cnt_next;
      to_cnt_reg <= to_cnt_next;
      fault_reg  <= seq_match(xgmii_rxd, xgmii_rxc, LF_CODE) ||
                    seq_match(xgmii_rxd, xgmii_rxc, RF_CODE);
      rf_reg     <= seq_match(xgmii_rxd, xgmii_rxc, RF_CODE);
      tx_dis_reg <= tx_dis_next;
      rst_reg    <= rst_next;
      up_reg     <= up_next;
      dn_cnt_reg <= dn_cnt_next;
    end
  end

  // Next state and counter updates; module presence/tx_fault override PLL loss, which overrides the rest.
  always_comb begin
    state_next  = state_reg;
    ph_cnt_next = ph_cnt_reg;
    to_cnt_next = '0;
    case (state_reg)
      DISABLED: begin
        state_next = WAIT_PLL;
      end
      WAIT_PLL: begin
        if (qplllock && reset_counter_done) state_next = RESET;
      end
      RESET: begin
        if (ph_cnt_reg == RST_LAST) state_next = WAIT_LINK;
        else ph_cnt_next = ph_cnt_reg + 1'b1;
      end
      WAIT_LINK: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        if (fault_reg) ph_cnt_next = '0;
        else if (ph_cnt_reg == OK_LAST) state_next = UP;
        else ph_cnt_next = ph_cnt_reg + 1'b1;
        if (state_next == WAIT_LINK && to_cnt_reg == TO_LAST) state_next = RESET;
      end
      UP: begin
        if (!fault_reg) ph_cnt_next = '0;
        else if (ph_cnt_reg == FLT_LAST) state_next = WAIT_LINK;
        else ph_cnt_next = ph_cnt_reg + 1'b1;
      end
      default: begin
        state_next = DISABLED;
      end
    endcase
    if (!qplllock && (state_reg inside {RESET, WAIT_LINK, UP})) state_next = WAIT_PLL;
    if (sfp_absent || sfp_tx_fault) state_next = DISABLED;
    if (state_next != state_reg) begin
      ph_cnt_next = '0;
      to_cnt_next = '0;
    end
  end

  // Output values for the state being entered, so the output registers move with the state.
  always_comb begin
    tx_dis_next = (state_next == DISABLED);
    rst_next    = (state_next inside {DISABLED, WAIT_PLL, RESET});
    up_next     = (state_next == UP);
    dn_cnt_next = dn_cnt_reg;
    if (state_reg == UP && state_next != UP && dn_cnt_reg != '1) dn_cnt_next = dn_cnt_reg + 1'b1;
  end

  assign sfp_tx_disable  = tx_dis_reg;
  assign port_rst        = rst_reg;
  assign link_up         = up_reg;
  assign remote_fault    = rf_reg;
  assign link_down_count = dn_cnt_reg;

endmodule

// File: rtl/sfp_link_mgr.sv
// Multi-port SFP+ link supervisor: one independent sfp_link_fsm per port, shared PLL status fanned out.
module sfp_link_mgr
  import sfp_link_mgr_pkg::*;
#(
  parameter int PORTS          = 2,
  parameter int RESET_CYCLES   = 256,
  parameter int LINK_OK_CYCLES = 1024,
  parameter int FAULT_CYCLES   = 4,
  parameter int LINK_TIMEOUT   = 1048576,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   qplllock,
  input  logic                   reset_counter_done,
  input  logic [PORTS-1:0]       sfp_absent,
  input  logic [PORTS-1:0]       sfp_tx_fault,
  input  logic [PORTS*64-1:0]    xgmii_rxd,
  input  logic [PORTS*8-1:0]     xgmii_rxc,
  output logic [PORTS-1:0]       sfp_tx_disable,
  output logic [PORTS-1:0]       port_rst,
  output logic [PORTS-1:0]       link_up,
  output logic [PORTS-1:0]       remote_fault,
  output logic [PORTS*CNT_W-1:0] link_down_count
);

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    sfp_link_fsm #(
      .RESET_CYCLES   (RESET_CYCLES),
      .LINK_OK_CYCLES (LINK_OK_CYCLES),
      .FAULT_CYCLES   (FAULT_CYCLES),
      .LINK_TIMEOUT   (LINK_TIMEOUT),
      .CNT_W          (CNT_W)
    ) u_fsm (
      .clk                (clk),
      .rst_n              (rst_n),
      .qplllock           (qplllock),
      .reset_counter_done (reset_counter_done),
      .sfp_absent         (sfp_absent[gi]),
      .sfp_tx_fault       (sfp_tx_fault[gi]),
      .xgmii_rxd          (xgmii_rxd[64*gi +: 64]),
      .xgmii_rxc          (xgmii_rxc[8*gi +: 8]),
      .sfp_tx_disable     (sfp_tx_disable[gi]),
      .port_rst           (port_rst[gi]),
      .link_up            (link_up[gi]),
      .remote_fault       (remote_fault[gi]),
      .link_down_count    (link_down_count[CNT_W*gi +: CNT_W])
    );
  end

endmodule

// File: tb/tb_sfp_link_mgr.sv
// Directed bench for sfp_link_mgr with a behavioural per-port model checked every cycle.
module tb_sfp_link_mgr;

  localparam int NP      = 2;
  localparam int RC      = 8;
  localparam int OKC     = 16;
  localparam int FC      = 4;
  localparam int TO      = 64;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [63:0] LF0_D  = 64'h070707070100009C;
  localparam logic [63:0] RF4_D  = 64'h0200009C07070707;
  localparam logic [7:0]  CTL_C  = 8'hFF;

  // Model modes, ordered so that ">= M_RST" means "past PLL wait".
  localparam int M_DIS = 0, M_PLL = 1, M_RST = 2, M_WL = 3, M_UP = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                qplllock, reset_counter_done;
  logic [NP-1:0]       sfp_absent, sfp_tx_fault;
  logic [NP*64-1:0]    xgmii_rxd;
  logic [NP*8-1:0]     xgmii_rxc;
  logic [NP-1:0]       sfp_tx_disable, port_rst, link_up, remote_fault;
  logic [NP*CW-1:0]    link_down_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sfp_link_mgr #(
    .PORTS(NP), .RESET_CYCLES(RC), .LINK_OK_CYCLES(OKC),
    .FAULT_CYCLES(FC), .LINK_TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .qplllock(qplllock), .reset_counter_done(reset_counter_done),
    .sfp_absent(sfp_absent), .sfp_tx_fault(sfp_tx_fault),
    .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .sfp_tx_disable(sfp_tx_disable), .port_rst(port_rst), .link_up(link_up),
    .remote_fault(remote_fault), .link_down_count(link_down_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit has_set(input logic [63:0] d, input logic [7:0] c, input logic [23:0] code);
    bit hit;
    hit = 0;
    for (int l = 0; l < 2; l++)
      if (c[4*l] && d[32*l +: 32] == {code, 8'h9C}) hit = 1;
    return hit;
  endfunction

  int m_mode[NP], m_age[NP], m_clean[NP], m_bad[NP], m_cnt[NP];
  bit m_fd[NP], m_rf[NP];
  int nm, clean_n, bad_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        m_mode[p] = M_DIS; m_age[p] = 0; m_clean[p] = 0; m_bad[p] = 0;
        m_cnt[p] = 0; m_fd[p] = 0; m_rf[p] = 0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        clean_n = m_fd[p] ? 0 : m_clean[p] + 1;
        bad_n   = m_fd[p] ? m_bad[p] + 1 : 0;
        nm = m_mode[p];
        case (m_mode[p])
          M_DIS: nm = M_PLL;
          M_PLL: if (qplllock && reset_counter_done) nm = M_RST;
          M_RST: if (m_age[p] + 1 == RC) nm = M_WL;
          M_WL:  if (clean_n == OKC) nm = M_UP; else if (m_age[p] + 1 == TO) nm = M_RST;
          default: if (bad_n == FC) nm = M_WL;
        endcase
        if (!qplllock && m_mode[p] >= M_RST) nm = M_PLL;
        if (sfp_absent[p] || sfp_tx_fault[p]) nm = M_DIS;
        if (m_mode[p] == M_UP && nm != M_UP && m_cnt[p] < CNT_MAX) m_cnt[p]++;
        if (nm != m_mode[p]) begin
          m_age[p] = 0; m_clean[p] = 0; m_bad[p] = 0;
        end else begin
          m_age[p]++; m_clean[p] = clean_n; m_bad[p] = bad_n;
        end
        m_mode[p] = nm;
        m_rf[p] = has_set(xgmii_rxd[64*p +: 64], xgmii_rxc[8*p +: 8], 24'h020000);
        m_fd[p] = m_rf[p] || has_set(xgmii_rxd[64*p +: 64], xgmii_rxc[8*p +: 8], 24'h010000);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  logic [NP-1:0]    e_txd, e_rst, e_up, e_rf;
  logic [NP*CW-1:0] e_cnt;
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      e_txd[p] = (m_mode[p] == M_DIS);
      e_rst[p] = (m_mode[p] <= M_RST);
      e_up[p]  = (m_mode[p] == M_UP);
      e_rf[p]  = m_rf[p];
      e_cnt[CW*p +: CW] = CW'(m_cnt[p]);
    end
    chk("cyc_tx_disable", 32'(sfp_tx_disable), 32'(e_txd));
    chk("cyc_port_rst", 32'(port_rst), 32'(e_rst));
    chk("cyc_link_up", 32'(link_up), 32'(e_up));
    chk("cyc_remote_fault", 32'(remote_fault), 32'(e_rf));
    chk("cyc_link_down_count", 32'(link_down_count), 32'(e_cnt));
  end

  // ---------------- directed stimulus ----------------
  task automatic set_rx(input int p, input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd[64*p +: 64] = d;
    xgmii_rxc[8*p +: 8]   = c;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_up(input int p, input int budget, input string name);
    int n;
    n = 0;
    while (!link_up[p] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(link_up[p]), 32'd1);
  endtask

  function automatic int cnt_of(input int p);
    return int'(link_down_count[CW*p +: CW]);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int t_txd, t_rf, t_up, r1, f1, r2;
    logic prev;
    rst_n = 1'b1;
    qplllock = 1'b1;
    reset_counter_done = 1'b1;
    sfp_absent = '0;
    sfp_tx_fault = '0;
    for (int p = 0; p < NP; p++) set_rx(p, IDLE_D, CTL_C);
    #1 rst_n = 1'b0;
    tick(3);

    $display("[%0t] reset state", $time);
    chk("rst_tx_disable", 32'(sfp_tx_disable), 32'h3);
    chk("rst_port_rst", 32'(port_rst), 32'h3);
    chk("rst_link_up", 32'(link_up), 32'h0);
    chk("rst_count", 32'(link_down_count), 32'h0);
    rst_n = 1'b1;

    $display("[%0t] bring-up", $time);
    t_txd = -1; t_rf = -1; t_up = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (t_txd < 0 && !sfp_tx_disable[0]) t_txd = k;
      if (t_rf < 0 && t_txd >= 0 && !port_rst[0]) t_rf = k;
      if (t_up < 0 && link_up[0]) t_up = k;
    end
    chk("bringup_txdis_fall", 32'(t_txd), 32'd1);
    chk("bringup_rst_hold", 32'(t_rf - t_txd), 32'd9);
    chk("bringup_link_delay", 32'(t_up - t_rf), 32'd16);
    chk("bringup_both_up", 32'(link_up), 32'h3);

    $display("[%0t] lane-0 local fault x3", $time);
    set_rx(0, LF0_D, CTL_C); tick(3);
    set_rx(0, IDLE_D, CTL_C); tick(3);
    chk("lf3_link_stays", 32'(link_up[0]), 32'd1);
    chk("lf3_count", 32'(cnt_of(0)), 32'd0);

    $display("[%0t] lane-0 local fault x4", $time);
    set_rx(0, LF0_D, CTL_C); tick(4);
    set_rx(0, IDLE_D, CTL_C); tick(3);
    chk("lf4_link_down", 32'(link_up[0]), 32'd0);
    chk("lf4_count", 32'(cnt_of(0)), 32'd1);
    wait_up(0, 40, "lf4_relink");

    $display("[%0t] lane-4 remote fault", $time);
    set_rx(0, RF4_D, CTL_C); tick(1);
    chk("rf_flag", 32'(remote_fault), 32'h1);
    tick(3);
    set_rx(0, IDLE_D, CTL_C); tick(2);
    chk("rf_link_down", 32'(link_up[0]), 32'd0);
    chk("rf_flag_clear", 32'(remote_fault), 32'h0);
    chk("rf_count", 32'(cnt_of(0)), 32'd2);
    wait_up(0, 40, "rf_relink");

    $display("[%0t] link timeout", $time);
    set_rx(0, LF0_D, CTL_C);
    r1 = -1; f1 = -1; r2 = -1;
    prev = port_rst[0];
    for (int k = 1; k <= 300 && r2 < 0; k++) begin
      @(negedge clk);
      if (port_rst[0] && !prev && r1 < 0) r1 = k;
      else if (!port_rst[0] && prev && r1 >= 0 && f1 < 0) f1 = k;
      else if (port_rst[0] && !prev && f1 >= 0) r2 = k;
      prev = port_rst[0];
    end
    chk("timeout_rst_len", 32'(f1 - r1), 32'd8);
    chk("timeout_period", 32'(r2 - f1), 32'd64);
    chk("timeout_count", 32'(cnt_of(0)), 32'd3);
    set_rx(0, IDLE_D, CTL_C);
    wait_up(0, 120, "timeout_relink");

    $display("[%0t] port1 tx_fault isolation", $time);
    sfp_tx_fault[1] = 1'b1; tick(1);
    chk("iso_p1_txdis", 32'(sfp_tx_disable[1]), 32'd1);
    chk("iso_p1_down", 32'(link_up[1]), 32'd0);
    chk("iso_p1_count", 32'(cnt_of(1)), 32'd1);
    chk("iso_p0_up", 32'(link_up[0]), 32'd1);
    sfp_tx_fault[1] = 1'b0; tick(1);

    $display("[%0t] qplllock loss", $time);
    qplllock = 1'b0; tick(2);
    chk("pll_port_rst", 32'(port_rst), 32'h3);
    chk("pll_txdis", 32'(sfp_tx_disable), 32'h0);
    chk("pll_link_up", 32'(link_up), 32'h0);
    chk("pll_p0_count", 32'(cnt_of(0)), 32'd4);
    qplllock = 1'b1;
    wait_up(0, 60, "pll_relink0");
    wait_up(1, 60, "pll_relink1");

    $display("[%0t] counter saturation", $time);
    for (int e = 0; e < 16; e++) begin
      sfp_tx_fault[1] = 1'b1; tick(1);
      sfp_tx_fault[1] = 1'b0;
      wait_up(1, 60, "sat_relink");
    end
    chk("sat_count", 32'(cnt_of(1)), 32'hF);
    chk("sat_p0_count", 32'(cnt_of(0)), 32'd4);

    $display("[%0t] async reset mid-UP", $time);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_disable", 32'(sfp_tx_disable), 32'h3);
    chk("arst_port_rst", 32'(port_rst), 32'h3);
    chk("arst_link_up", 32'(link_up), 32'h0);
    chk("arst_remote_fault", 32'(remote_fault), 32'h0);
    chk("arst_count", 32'(link_down_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_up(0, 60, "arst_relink");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
